gen_counter: RTL
================

GEN_COUNTER -- requirements
Module: gen_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal value; count range 0..MAX_VAL; MAX_VAL SHALL be at least 1 and at most 2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at range limits, 1 = hold at range limits.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  count enable.
REQ-007 clr  input  1  synchronous clear of count to 0.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 up_dn  input  1  direction; 1 = up, 0 = down.
REQ-011 sticky_clr  input  1  clears ov_sticky and un_sticky.
REQ-012 count  output  WIDTH  current count, registered.
REQ-013 ov  output  1  one-cycle overflow pulse, registered.
REQ-014 un  output  1  one-cycle underflow pulse, registered.
REQ-015 ov_sticky  output  1  latched overflow indication.
REQ-016 un_sticky  output  1  latched underflow indication.
REQ-017 tc  output  1  combinational terminal count: (up_dn && count==MAX_VAL) || (!up_dn && count==0).

Function
REQ-018 Per-edge priority SHALL be reset > clr > load > en; with none of these active, count holds.
REQ-019 clr: count <= 0; ov and un <= 0.
REQ-020 load: count <= min(load_val, MAX_VAL); ov and un <= 0; up_dn ignored.
REQ-021 en, up_dn=1, count<MAX_VAL: count <= count+1.
REQ-022 en, up_dn=0, count>0: count <= count-1.
REQ-023 en, up_dn=1, count==MAX_VAL: count <= 0 if SATURATE=0, otherwise count holds at MAX_VAL; in both modes ov <= 1 for exactly the next cycle.
REQ-024 en, up_dn=0, count==0: count <= MAX_VAL if SATURATE=0, otherwise count holds at 0; in both modes un <= 1 for exactly the next cycle.
REQ-025 ov and un SHALL be 0 in every cycle not covered by REQ-023 or REQ-024, and never both 1.
REQ-026 A direction change takes effect on the same edge; no turnaround cycle.
REQ-027 Arithmetic SHALL be performed at WIDTH+1 bits internally; a count value above MAX_VAL SHALL never be produced.
REQ-028 ov_sticky is set on the edge where ov is set; un_sticky likewise with un; each holds until sticky_clr.
REQ-029 If sticky_clr coincides with a new ov/un event, set SHALL win; clr and load SHALL NOT affect the sticky flags.
REQ-030 Latency: count, ov and un update on the edge after the inputs are sampled; tc follows count and up_dn combinationally.

Reset
REQ-031 On a clk edge with reset=0: count=0, ov=0, un=0, ov_sticky=0, un_sticky=0, all other inputs ignored.
REQ-032 Reset asserted mid-count SHALL take effect on that edge; counting resumes on the first edge with reset=1.
REQ-033 No asynchronous reset path; the block SHALL NOT be sensitive to reset outside clk edges.

Structure
REQ-034 Package gen_counter_pkg SHALL hold DIR_UP=1, DIR_DOWN=0, MODE_WRAP=0, MODE_SAT=1 and the range-check function for MAX_VAL.
REQ-035 Sub-module gen_counter_flag (set/clear sticky bit, set-priority, synchronous active-low reset) SHALL be instantiated twice.
REQ-036 Elaboration SHALL fail for MAX_VAL outside 1..2**WIDTH-1.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-037 Reset, then en=1, up_dn=1 for 12 edges -> count 1..9,0,1,2; ov=1 only in the cycle count=0; ov_sticky=1 from then on.
REQ-038 load_val=3, load, then en=1, up_dn=0 for 5 edges -> 2,1,0,9,8; un pulse coincides with count=9; tc=1 while count=0.
REQ-039 SATURATE=1: load 8, up 3 edges -> 9,9,9; ov pulses on the 2nd and 3rd edges; down from 1 -> 0,0; un pulses on the second edge.
REQ-040 load_val=15 -> count=9; clr with load and en also active -> count=0; sticky flags unchanged.
REQ-041 sticky_clr on the same edge as a wrap 9->0 -> ov_sticky stays 1; sticky_clr alone on the next edge -> 0.
REQ-042 reset=0 at count=5 mid-count -> count=0 and all flags 0 on that edge; reset pulse between edges without a clk edge -> no change.

Source files
------------

// File: rtl/gen_counter_pkg.sv
// Shared constants and parameter checks for the gen_counter block.
package gen_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam bit   MODE_WRAP = 1'b0;
    localparam bit   MODE_SAT  = 1'b1;

    // Legal terminal values are 1..2**width-1.
    function automatic bit max_val_ok(input int unsigned width, input longint unsigned max_val);
        longint unsigned limit;
        limit = (64'd1 << width) - 64'd1;
        return (max_val >= 64'd1) && (max_val <= limit);
    endfunction

endpackage

// File: rtl/gen_counter_flag.sv
// Sticky status bit: set has priority over clear; synchronous active-low reset.
module gen_counter_flag (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic flag
);

    logic flag_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            flag_q <= 1'b0;
        end else if (set) begin
            flag_q <= 1'b1;
        end else if (clr) begin
            flag_q <= 1'b0;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/gen_counter.sv
// Up/down counter over 0..MAX_VAL with wrap or saturate at the limits,
// registered overflow/underflow pulses and sticky event flags.
module gen_counter
    import gen_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] count,
    output logic             ov,
    output logic             un,
    output logic             ov_sticky,
    output logic             un_sticky,
    output logic             tc
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("gen_counter: WIDTH must be in 2..32");
    end
    if (!max_val_ok(WIDTH, MAX_VAL)) begin : g_bad_max_val
        $error("gen_counter: MAX_VAL must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             ov_q, ov_d;
    logic             un_q, un_d;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   count_inc;
    logic [WIDTH:0]   count_dec;
    logic             at_max;
    logic             at_zero;

    assign count_ext = {1'b0, count_q};
    assign count_inc = count_ext + {{WIDTH{1'b0}}, 1'b1};
    assign count_dec = count_ext - {{WIDTH{1'b0}}, 1'b1};
    assign at_max    = (count_q == MAX_W);
    assign at_zero   = (count_q == '0);

    always_comb begin
        count_d = count_q;
        ov_d    = 1'b0;
        un_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_W) ? MAX_W : load_val;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (at_max) begin
                    ov_d    = 1'b1;
                    count_d = (SATURATE == MODE_SAT) ? MAX_W : '0;
                end else begin
                    count_d = count_inc[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    un_d    = 1'b1;
                    count_d = (SATURATE == MODE_SAT) ? '0 : MAX_W;
                end else begin
                    count_d = count_dec[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ov_q    <= ov_d;
            un_q    <= un_d;
        end
    end

    gen_counter_flag u_ov_flag (
        .clk   (clk),
        .reset (reset),
        .set   (ov_d),
        .clr   (sticky_clr),
        .flag  (ov_sticky)
    );

    gen_counter_flag u_un_flag (
        .clk   (clk),
        .reset (reset),
        .set   (un_d),
        .clr   (sticky_clr),
        .flag  (un_sticky)
    );

    assign count = count_q;
    assign ov    = ov_q;
    assign un    = un_q;
    assign tc    = (up_dn && at_max) || (!up_dn && at_zero);

endmodule
